// File: rtl/secded72_pkg.sv
`default_nettype none
// ============================================================================
// Module   : secded72_pkg
// Brief    : Shared SEC-DED (72,64) H-matrix, widths and check-bit helpers.
// Revision : 1.0
// ============================================================================
package secded72_pkg;

    localparam int DATA_W  = 64;
    localparam int CHK_W   = 8;
    localparam int CW_W    = 72;
    localparam int TAG_W   = 8;
    localparam int FRAME_W = 80;

    // Column of the H-matrix for each data bit; check bit k has column 1<<k.
    localparam logic [CHK_W-1:0] SECDED_COL [0:DATA_W-1] = '{
        8'h23, 8'h43, 8'h83, 8'h3D, 8'h45, 8'h85, 8'h89, 8'h49,
        8'h46, 8'h86, 8'h07, 8'h7A, 8'h8A, 8'h0B, 8'h13, 8'h92,
        8'h8C, 8'h0D, 8'h0E, 8'hF4, 8'h15, 8'h16, 8'h26, 8'h25,
        8'h19, 8'h1A, 8'h1C, 8'hE9, 8'h2A, 8'h2C, 8'h4C, 8'h4A,
        8'h32, 8'h34, 8'h38, 8'hD3, 8'h54, 8'h58, 8'h98, 8'h94,
        8'h64, 8'h68, 8'h70, 8'hA7, 8'hA8, 8'hB0, 8'h31, 8'h29,
        8'hC8, 8'hD0, 8'hE0, 8'h4F, 8'h51, 8'h61, 8'h62, 8'h52,
        8'h91, 8'hA1, 8'hC1, 8'h9E, 8'hA2, 8'hC2, 8'hC4, 8'hA4
    };

    // Data bits that participate in check bit k (one row of the H-matrix).
    function automatic logic [DATA_W-1:0] secded_row(input int k);
        logic [DATA_W-1:0] row;
        row = '0;
        for (int i = 0; i < DATA_W; i++) begin
            row[i] = SECDED_COL[i][k];
        end
        return row;
    endfunction

    function automatic logic [CHK_W-1:0] secded_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        chk = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                chk = chk ^ SECDED_COL[i];
            end
        end
        return chk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded72_chkgen.sv
`default_nettype none
// ============================================================================
// Module   : secded72_chkgen
// Brief    : Combinational SEC-DED (72,64) check-bit generator.
// Revision : 1.0
// ============================================================================
module secded72_chkgen
    import secded72_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  check
);

    // Each check bit is the parity of the data bits selected by its H-matrix row.
    for (genvar k = 0; k < CHK_W; k++) begin : g_chk
        localparam logic [DATA_W-1:0] c_row = secded_row(k);
        assign check[k] = ^(data & c_row);
    end

endmodule
`default_nettype wire

// File: rtl/secded72_enc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : secded72_enc_pipe
// Brief    : Two-stage valid/ready SEC-DED (72,64) encoder with tag passthrough
//            and optional codeword error injection.
// Revision : 1.0
// ============================================================================
module secded72_enc_pipe
    import secded72_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int INJ_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [CW_W-1:0]    inj_mask,
    input  logic               inj_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_frame,
    output logic [CNT_W-1:0]   word_cnt
);

    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_s1_data;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [CW_W-1:0]    r_s1_mask;
    logic               r_s2_valid;
    logic [FRAME_W-1:0] r_s2_frame;
    logic [CNT_W-1:0]   r_word_cnt;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_in_xfer;
    logic [CW_W-1:0]    w_inj_mask;
    logic [CHK_W-1:0]   w_check;

    // in_ready depends only on stage state and out_ready, never on in_valid.
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_adv;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_in_xfer = in_valid && in_ready;

    if (INJ_EN != 0) begin : g_inj
        assign w_inj_mask = inj_en ? inj_mask : '0;
    end else begin : g_no_inj
        assign w_inj_mask = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
            r_s1_mask  <= '0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
            r_s1_tag   <= in_tag;
            r_s1_mask  <= w_inj_mask;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    secded72_chkgen u_chkgen (
        .data  (r_s1_data),
        .check (w_check)
    );

    // The tag sits outside the codeword, so the mask never touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_frame <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_frame <= {r_s1_tag, {w_check, r_s1_data} ^ r_s1_mask};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_in_xfer) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_frame = r_s2_frame;
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_secded72_enc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_secded72_enc_pipe
// Brief    : Self-checking bench for secded72_enc_pipe against a parity model.
// Revision : 1.0
// ============================================================================
module tb_secded72_enc_pipe;

    localparam logic [7:0] COL [0:63] = '{
        8'h23, 8'h43, 8'h83, 8'h3D, 8'h45, 8'h85, 8'h89, 8'h49,
        8'h46, 8'h86, 8'h07, 8'h7A, 8'h8A, 8'h0B, 8'h13, 8'h92,
        8'h8C, 8'h0D, 8'h0E, 8'hF4, 8'h15, 8'h16, 8'h26, 8'h25,
        8'h19, 8'h1A, 8'h1C, 8'hE9, 8'h2A, 8'h2C, 8'h4C, 8'h4A,
        8'h32, 8'h34, 8'h38, 8'hD3, 8'h54, 8'h58, 8'h98, 8'h94,
        8'h64, 8'h68, 8'h70, 8'hA7, 8'hA8, 8'hB0, 8'h31, 8'h29,
        8'hC8, 8'hD0, 8'hE0, 8'h4F, 8'h51, 8'h61, 8'h62, 8'h52,
        8'h91, 8'hA1, 8'hC1, 8'h9E, 8'hA2, 8'hC2, 8'hC4, 8'hA4
    };

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        inj_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_tag = '0;
    logic [71:0] inj_mask = '0;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [79:0] a_out_frame, b_out_frame;
    logic [31:0] a_word_cnt;
    logic [3:0]  b_word_cnt;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    secded72_enc_pipe #(.CNT_W(32), .INJ_EN(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_tag(in_tag), .inj_mask(inj_mask), .inj_en(inj_en),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_frame(a_out_frame),
        .word_cnt(a_word_cnt)
    );

    secded72_enc_pipe #(.CNT_W(4), .INJ_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_tag(in_tag), .inj_mask(inj_mask), .inj_en(inj_en),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_frame(b_out_frame),
        .word_cnt(b_word_cnt)
    );

    // Pending directed words, accepted words (effective mask) and observed frames.
    logic [63:0] p_d[$];
    logic [7:0]  p_t[$];
    logic [71:0] p_m[$];
    logic        p_e[$];
    logic [63:0] s_d[$];
    logic [7:0]  s_t[$];
    logic [71:0] s_m[$];
    int          s_c[$];
    logic [79:0] g_a[$];
    logic [79:0] g_b[$];
    int          g_c[$];

    // Check bit k = odd count of set data bits whose column has bit k set.
    function automatic logic [7:0] ref_check(input logic [63:0] d);
        logic [7:0] r;
        logic [7:0] c;
        int ones;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            ones = 0;
            for (int i = 0; i < 64; i++) begin
                c = COL[i];
                if (d[i] && c[k]) ones++;
            end
            r[k] = (ones % 2) == 1;
        end
        return r;
    endfunction

    function automatic logic [79:0] ref_frame(input logic [63:0] d, input logic [7:0] t,
                                              input logic [71:0] m);
        return {t, {ref_check(d), d} ^ m};
    endfunction

    function automatic logic [7:0] syndrome(input logic [71:0] cw);
        return ref_check(cw[63:0]) ^ cw[71:64];
    endfunction

    function automatic logic [71:0] rand_mask();
        logic [71:0] m;
        m = '0;
        m[$urandom_range(0, 71)] = 1'b1;
        if ($urandom_range(0, 1) == 1) m[$urandom_range(0, 71)] = 1'b1;
        return m;
    endfunction

    task automatic push_word(input logic [63:0] d, input logic [7:0] t,
                             input logic [71:0] m, input logic e);
        p_d.push_back(d); p_t.push_back(t); p_m.push_back(m); p_e.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: out_ready=1, valid always; 1: out_ready 1,0,0 pattern; 2: random both.
    task automatic run_stream(input int n, input int mode, input bit use_inj);
        int sent = 0;
        int t = 0;
        bit have = 0;
        logic [63:0] cd;
        logic [7:0]  ct;
        logic [71:0] cm;
        logic        ce;
        s_d.delete(); s_t.delete(); s_m.delete(); s_c.delete();
        g_a.delete(); g_b.delete(); g_c.delete();
        while ((sent < n || g_a.size() < n) && t < n * 8 + 20) begin
            @(negedge clk);
            if (!have && sent < n) begin
                if (p_d.size() > 0) begin
                    cd = p_d.pop_front(); ct = p_t.pop_front();
                    cm = p_m.pop_front(); ce = p_e.pop_front();
                end else begin
                    cd = {$urandom, $urandom}; ct = 8'($urandom);
                    cm = rand_mask(); ce = use_inj && ($urandom_range(0, 1) == 1);
                end
                have = 1;
            end
            in_valid = have && (mode != 2 || $urandom_range(0, 3) != 0);
            if (in_valid) begin
                in_data = cd; in_tag = ct; inj_mask = cm; inj_en = ce;
            end else begin
                in_data = {$urandom, $urandom}; inj_mask = rand_mask(); inj_en = use_inj;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (t % 3 == 0);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (a_out_valid && out_ready) begin
                g_a.push_back(a_out_frame); g_b.push_back(b_out_frame); g_c.push_back(cyc);
            end
            if (in_valid && a_in_ready) begin
                s_d.push_back(cd); s_t.push_back(ct);
                s_m.push_back(ce ? cm : 72'h0); s_c.push_back(cyc);
                have = 0;
                sent++;
            end
            t++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; inj_en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        n_cmp++; if (a_out_frame !== 80'h0) begin n_fail++; $display("FAIL reset_out_frame: got %h expected 0", a_out_frame); end
        n_cmp++; if (a_word_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d expected 0", a_word_cnt); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        n_cmp++; if (b_out_valid !== 1'b0 || b_word_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_b: got valid %b cnt %0d expected 0 0", b_out_valid, b_word_cnt); end
    endtask

    task automatic test_directed();
        do_reset();
        push_word(64'h0, 8'h5A, rand_mask(), 1'b0);
        push_word(64'h1, 8'($urandom), rand_mask(), 1'b0);
        push_word(64'h3, 8'($urandom), rand_mask(), 1'b0);
        push_word(64'h8000000000000001, 8'($urandom), rand_mask(), 1'b0);
        run_stream(4, 0, 1'b0);
        n_cmp++; if (g_a.size() != 4) begin n_fail++; $display("FAIL directed_count: got %0d expected 4", g_a.size()); end
        if (g_a.size() == 4) begin
            n_cmp++; if (g_a[0] !== 80'h5A_00_0000000000000000) begin n_fail++; $display("FAIL directed_zero: got %h expected 5a000000000000000000", g_a[0]); end
            n_cmp++; if (g_a[1][71:64] !== 8'h23) begin n_fail++; $display("FAIL directed_d1: got %h expected 23", g_a[1][71:64]); end
            n_cmp++; if (g_a[2][71:64] !== 8'h60) begin n_fail++; $display("FAIL directed_d3: got %h expected 60", g_a[2][71:64]); end
            n_cmp++; if (g_a[3][71:64] !== 8'h87) begin n_fail++; $display("FAIL directed_d63_0: got %h expected 87", g_a[3][71:64]); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (g_c[i] - s_c[i] != 2) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 2", i, g_c[i] - s_c[i]); end
            end
        end
    endtask

    task automatic test_walking();
        logic [7:0] exp_c;
        for (int i = 0; i < 64; i++) push_word(64'h1 << i, 8'($urandom), rand_mask(), 1'b0);
        run_stream(64, 0, 1'b0);
        n_cmp++; if (g_a.size() != 64) begin n_fail++; $display("FAIL walk_count: got %0d expected 64", g_a.size()); end
        for (int i = 0; i < 64 && i < g_a.size(); i++) begin
            exp_c = COL[i];
            n_cmp++; if (g_a[i][71:64] !== exp_c) begin n_fail++; $display("FAIL walk_check[%0d]: got %h expected %h", i, g_a[i][71:64], exp_c); end
            n_cmp++; if (syndrome(g_a[i][71:0]) !== 8'h00) begin n_fail++; $display("FAIL walk_syndrome[%0d]: got %h expected 00", i, syndrome(g_a[i][71:0])); end
            n_cmp++; if (g_a[i] !== ref_frame(s_d[i], s_t[i], 72'h0)) begin n_fail++; $display("FAIL walk_frame[%0d]: got %h expected %h", i, g_a[i], ref_frame(s_d[i], s_t[i], 72'h0)); end
        end
    endtask

    task automatic test_random_stream();
        run_stream(150, 2, 1'b1);
        n_cmp++; if (g_a.size() != 150 || g_b.size() != 150) begin n_fail++; $display("FAIL rand_count: got %0d/%0d expected 150", g_a.size(), g_b.size()); end
        for (int i = 0; i < g_a.size() && i < s_d.size(); i++) begin
            n_cmp++; if (g_a[i] !== ref_frame(s_d[i], s_t[i], s_m[i])) begin n_fail++; $display("FAIL rand_frame_a[%0d]: got %h expected %h", i, g_a[i], ref_frame(s_d[i], s_t[i], s_m[i])); end
            n_cmp++; if (g_b[i] !== ref_frame(s_d[i], s_t[i], 72'h0)) begin n_fail++; $display("FAIL rand_frame_b[%0d]: got %h expected %h", i, g_b[i], ref_frame(s_d[i], s_t[i], 72'h0)); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d1;
        logic [7:0]  t1;
        do_reset();
        run_stream(10, 1, 1'b0);
        n_cmp++; if (g_a.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d expected 10", g_a.size()); end
        for (int i = 0; i < g_a.size() && i < s_d.size(); i++) begin
            n_cmp++; if (g_a[i] !== ref_frame(s_d[i], s_t[i], 72'h0)) begin n_fail++; $display("FAIL bp_frame[%0d]: got %h expected %h", i, g_a[i], ref_frame(s_d[i], s_t[i], 72'h0)); end
        end
        n_cmp++; if (a_word_cnt !== 32'd10) begin n_fail++; $display("FAIL bp_word_cnt: got %0d expected 10", a_word_cnt); end
        // Stall: two words fill the pipe, then in_ready drops and the frame holds.
        d1 = {$urandom, $urandom};
        t1 = 8'($urandom);
        @(negedge clk);
        in_data = d1; in_tag = t1; inj_en = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready0: got %b expected 1", a_in_ready); end
        @(negedge clk);
        in_data = {$urandom, $urandom};
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready1: got %b expected 1", a_in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            inj_en = 1'b1; inj_mask = rand_mask();
            #1;
            n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_low[%0d]: got %b expected 0", k, a_in_ready); end
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_frame !== ref_frame(d1, t1, 72'h0)) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b %h expected 1 %h", k, a_out_valid, a_out_frame, ref_frame(d1, t1, 72'h0)); end
        end
        n_cmp++; if (a_word_cnt !== 32'd12) begin n_fail++; $display("FAIL stall_word_cnt: got %0d expected 12", a_word_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; inj_en = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", a_out_valid); end
        n_cmp++; if (a_word_cnt !== 32'h0 || b_word_cnt !== 4'h0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d/%0d expected 0", a_word_cnt, b_word_cnt); end
        rst = 1'b0;
        run_stream(1, 0, 1'b0);
        n_cmp++; if (g_a.size() != 1) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 1", g_a.size()); end
        if (g_a.size() == 1) begin
            n_cmp++; if (g_c[0] - s_c[0] != 2) begin n_fail++; $display("FAIL mid_reset_latency: got %0d expected 2", g_c[0] - s_c[0]); end
            n_cmp++; if (g_a[0] !== ref_frame(s_d[0], s_t[0], 72'h0)) begin n_fail++; $display("FAIL mid_reset_frame: got %h expected %h", g_a[0], ref_frame(s_d[0], s_t[0], 72'h0)); end
        end
    endtask

    task automatic test_injection();
        logic [63:0] dr;
        logic [7:0]  tr;
        dr = {$urandom, $urandom};
        tr = 8'($urandom);
        do_reset();
        push_word(64'h0, 8'hC3, 72'h1 << 5, 1'b1);
        push_word(64'h0, 8'h3C, 72'h3, 1'b1);
        push_word(dr, tr, rand_mask(), 1'b0);
        push_word(64'h0, 8'h11, 72'h1 << 70, 1'b1);
        run_stream(4, 0, 1'b1);
        n_cmp++; if (g_a.size() != 4) begin n_fail++; $display("FAIL inj_count: got %0d expected 4", g_a.size()); end
        if (g_a.size() == 4) begin
            n_cmp++; if (g_a[0] !== {8'hC3, 72'h20}) begin n_fail++; $display("FAIL inj_single_frame: got %h expected c3...20", g_a[0]); end
            n_cmp++; if (syndrome(g_a[0][71:0]) !== 8'h85) begin n_fail++; $display("FAIL inj_single_syn: got %h expected 85", syndrome(g_a[0][71:0])); end
            n_cmp++; if (syndrome(g_a[1][71:0]) !== 8'h60) begin n_fail++; $display("FAIL inj_double_syn: got %h expected 60", syndrome(g_a[1][71:0])); end
            n_cmp++; if (g_a[2] !== ref_frame(dr, tr, 72'h0)) begin n_fail++; $display("FAIL inj_disabled_frame: got %h expected %h", g_a[2], ref_frame(dr, tr, 72'h0)); end
            n_cmp++; if (syndrome(g_a[3][71:0]) !== 8'h40 || g_a[3][79:72] !== 8'h11) begin n_fail++; $display("FAIL inj_check_bit: got %h expected syn 40 tag 11", g_a[3]); end
            n_cmp++; if (g_b[0] !== {8'hC3, 72'h0} || g_b[1] !== {8'h3C, 72'h0}) begin n_fail++; $display("FAIL inj_param_off: got %h %h expected c3..0 3c..0", g_b[0], g_b[1]); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        run_stream(17, 0, 1'b0);
        n_cmp++; if (a_word_cnt !== 32'd17) begin n_fail++; $display("FAIL wrap_cnt32: got %0d expected 17", a_word_cnt); end
        n_cmp++; if (b_word_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt4: got %0d expected 1", b_word_cnt); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_walking();
        test_random_stream();
        test_backpressure();
        test_reset_mid();
        test_injection();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
